// File: rtl/phase_decoder.sv
// phase_decoder: recovers a 0..8 phase code from an oscillator's rising-edge offset against the reference
module phase_decoder #(
  parameter int PERIOD = 16,
  parameter int HIGH_LEN = 8,
  parameter int MAX_PHASE = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ref_osc,
  input  logic       osc_in,
  output logic [3:0] phase,
  output logic       phase_valid,
  output logic       err,
  output logic       lock
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, REPORT} state_t;
  state_t state, state_n;
  logic ref_d, osc_d, last_ok;
  logic [3:0] cnt, off_r, hi_cnt, match_cnt, last_phase;
  logic ref_rise, osc_rise, osc_fall, bad, same;
  logic [3:0] offset, match_n;
  assign ref_rise = ref_osc & ~ref_d;
  assign osc_rise = osc_in & ~osc_d;
  assign osc_fall = ~osc_in & osc_d;
  assign offset = ref_rise ? 4'd0 : cnt;
  assign bad = (off_r > 4'(MAX_PHASE)) || (hi_cnt != 4'(HIGH_LEN));
  assign same = last_ok && (off_r == last_phase);
  assign match_n = bad ? 4'd0 : same ? ((match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1) : 4'd1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = ref_rise ? WAIT_RISE : IDLE;
      WAIT_RISE: state_n = osc_rise ? MEASURE : WAIT_RISE;
      MEASURE:   state_n = osc_fall ? REPORT : MEASURE;
      REPORT:    state_n = osc_rise ? MEASURE : WAIT_RISE;
      default:   state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ref_d <= 1'b0;
      osc_d <= 1'b0;
      cnt <= 4'd0;
      off_r <= 4'd0;
      hi_cnt <= 4'd0;
      match_cnt <= 4'd0;
      last_phase <= 4'd0;
      last_ok <= 1'b0;
      phase <= 4'd0;
      phase_valid <= 1'b0;
      err <= 1'b0;
      lock <= 1'b0;
    end else begin
      state <= state_n;
      ref_d <= ref_osc;
      osc_d <= osc_in;
      cnt <= ref_rise ? 4'd1 : (cnt == 4'(PERIOD - 1)) ? 4'd0 : cnt + 4'd1;
      phase_valid <= 1'b0;
      if (!enable) begin
        lock <= 1'b0;
        match_cnt <= 4'd0;
        last_ok <= 1'b0;
      end else begin
        // a rise sampled during REPORT starts the next measurement immediately
        if ((state == WAIT_RISE || state == REPORT) && osc_rise) begin
          off_r <= offset;
          hi_cnt <= 4'd1;
        end else if (state == MEASURE && osc_in && hi_cnt != 4'd15) begin
          hi_cnt <= hi_cnt + 4'd1;
        end
        if (state == REPORT) begin
          phase <= off_r;
          err <= bad;
          phase_valid <= 1'b1;
          match_cnt <= match_n;
          lock <= match_n >= 4'(LOCK_COUNT);
          if (!bad) begin
            last_phase <= off_r;
            last_ok <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_phase_decoder.sv
// tb_phase_decoder: directed phase, width, lock, enable and reset vectors with a strobe queue
module tb_phase_decoder;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b1, ref_osc = 1'b1, osc_in = 1'b0;
  logic [3:0] phase;
  logic phase_valid, err, lock;
  typedef struct {int ph; int e; int lk; int lat;} strobe_t;
  strobe_t q[$];
  int t = 0, edges = 0, last_hi = -100, mode = 2, p_off = 0, p_wid = 8, tests = 0, fails = 0;
  phase_decoder dut (
    .clk(clk), .rst(rst), .enable(enable), .ref_osc(ref_osc), .osc_in(osc_in),
    .phase(phase), .phase_valid(phase_valid), .err(err), .lock(lock)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // mode 0: ref-aligned pattern at offset p_off of width p_wid; 1: stuck high; 2: stuck low
  task automatic tick();
    strobe_t s;
    @(posedge clk);
    edges++;
    if (osc_in) last_hi = edges;
    #1;
    if (phase_valid) begin
      s.ph = int'(phase);
      s.e = int'(err);
      s.lk = int'(lock);
      s.lat = edges - last_hi;
      q.push_back(s);
    end
    t++;
    ref_osc = (t % 16) < 8;
    osc_in = (mode == 0) ? ((((t - p_off) % 16 + 16) % 16) < p_wid) : (mode == 1);
  endtask
  task automatic expect_strobe(string tag, int ph, int e, int lk, int lat);
    int n = 0;
    strobe_t s;
    while (q.size() == 0 && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, int'(q.size() > 0), 1);
    if (q.size() > 0) begin
      s = q.pop_front();
      check({tag, "_phase"}, s.ph, ph);
      check({tag, "_err"}, s.e, e);
      if (lk >= 0) check({tag, "_lock"}, s.lk, lk);
      if (lat >= 0) check({tag, "_lat"}, s.lat, lat);
    end
  endtask
  task automatic no_strobe(string tag, int n);
    repeat (n) tick();
    check({tag, "_none"}, q.size(), 0);
    q.delete();
  endtask
  task automatic start_pat(int p, int w);
    mode = 2;
    while ((t + 1) % 16 != p) tick();
    mode = 0;
    p_off = p;
    p_wid = w;
  endtask
  initial begin
    repeat (4) tick();
    check("rst_phase", int'(phase), 0);
    check("rst_valid", int'(phase_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_lock", int'(lock), 0);
    mode = 0;
    p_off = 3;
    p_wid = 8;
    while (t % 16 != 9) tick();
    rst = 1'b0;
    no_strobe("early", 14);
    expect_strobe("early_next", 3, 0, -1, 2);
    for (int p = 0; p <= 8; p++) begin
      start_pat(p, 8);
      expect_strobe($sformatf("sweep%0d_a", p), p, 0, -1, 2);
      expect_strobe($sformatf("sweep%0d_b", p), p, 0, -1, 2);
    end
    start_pat(12, 8);
    expect_strobe("off12", 12, 1, 0, 2);
    start_pat(3, 6);
    expect_strobe("wid6", 3, 1, 0, 2);
    start_pat(5, 8);
    for (int k = 0; k < 4; k++) expect_strobe($sformatf("lock5_%0d", k), 5, 0, int'(k == 3), 2);
    start_pat(6, 8);
    for (int k = 0; k < 4; k++) expect_strobe($sformatf("lock6_%0d", k), 6, 0, int'(k == 3), 2);
    start_pat(6, 5);
    expect_strobe("lock_err", 6, 1, 0, 2);
    mode = 2;
    no_strobe("stuck_lo", 40);
    while ((t + 1) % 16 != 2) tick();
    mode = 1;
    repeat (20) tick();
    check("stuck_hi_wait", q.size(), 0);
    mode = 2;
    expect_strobe("stuck_hi", 2, 1, 0, 2);
    while ((t + 1) % 16 != 8) tick();
    mode = 1;
    repeat (8) tick();
    mode = 2;
    tick();
    mode = 1;
    repeat (8) tick();
    mode = 2;
    expect_strobe("b2b_first", 8, 0, 0, -1);
    expect_strobe("b2b_second", 1, 0, 0, 2);
    start_pat(4, 8);
    for (int k = 0; k < 4; k++) expect_strobe($sformatf("lock4_%0d", k), 4, 0, int'(k == 3), 2);
    while (t % 16 != 7) tick();
    enable = 1'b0;
    tick();
    check("en_off_lock", int'(lock), 0);
    check("en_off_phase", int'(phase), 4);
    no_strobe("en_off", 10);
    enable = 1'b1;
    expect_strobe("en_resume", 4, 0, -1, 2);
    while (t % 16 != 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_phase", int'(phase), 0);
    check("midrst_valid", int'(phase_valid), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_lock", int'(lock), 0);
    no_strobe("midrst", 10);
    expect_strobe("midrst_resume", 4, 0, 0, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
